// File: rtl/interrupt_controller_pkg.sv
// Shared encodings for the interrupt responder: IRQ source codes and FSM states.
// IRQ code 2 is reserved and never driven onto INT_IRQ.
// The FSM state type is used only inside the top-level controller.
package interrupt_controller_pkg;

  localparam logic [1:0] IRQ_FRAME = 2'd0;
  localparam logic [1:0] IRQ_KBD   = 2'd1;
  localparam logic [1:0] IRQ_NONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/interrupt_controller_kbd_fifo.sv
// Synchronous scancode queue with a registered head and an occupancy counter.
// Pop is applied before push, so push+pop on a full queue drops nothing.
// Pop on an empty queue is ignored; push on a full queue (without pop) is dropped.
module kbd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= dat_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Responder for the IRQ/IACK/IEND handshake: frame ticks and queued scancodes, one at a time.
// An event is seen one cycle after tick/push; INT_IRQ becomes valid the cycle after that.
// Each interrupt is held until IACK, then serviced until IEND; late events are recorded meanwhile.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int TICK_DIV   = 833333,
  parameter int FIFO_DEPTH = 4,
  parameter int WDT_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic       KEY_VALID,
  input  logic [7:0] KEY_CODE,
  output logic [1:0] INT_IRQ,
  input  logic       INT_IACK,
  input  logic       INT_IEND,
  output logic [7:0] KBD_KEY,
  output logic [7:0] FRAME_OVR_CNT,
  output logic       KBD_OVERFLOW,
  output logic       PROTO_ERROR,
  output logic       WDT_TIMEOUT
);

  localparam int             DW        = $clog2(TICK_DIV);
  localparam logic [DW-1:0]  DIV_LAST  = DW'(TICK_DIV - 1);
  localparam int             WW        = $clog2(WDT_CYCLES + 1);
  localparam logic [WW-1:0]  WDT_LIMIT = WW'(WDT_CYCLES);

  state_e        state_q;
  logic [DW-1:0] div_q;
  logic [WW-1:0] wdt_q, wdt_next;
  logic          frame_pend_q, sel_kbd_q, last_frame_q;
  logic [1:0]    irq_q;
  logic [7:0]    key_q, ovr_q;
  logic          kbd_ovf_q, proto_q, wdt_to_q;

  logic          tick, push, ack_ok, frame_clr, pop, pick_kbd;
  logic [7:0]    fifo_head;
  logic          fifo_full, fifo_empty;

  assign tick      = ENABLE && (div_q == DIV_LAST);
  assign push      = ENABLE && KEY_VALID;
  assign ack_ok    = (state_q == ST_PRESENT) && INT_IACK;
  assign frame_clr = ack_ok && !sel_kbd_q;
  assign pop       = ack_ok && sel_kbd_q;
  // Keyboard goes first only if a key waits and either no frame is pending or frame went last.
  assign pick_kbd  = !fifo_empty && (!frame_pend_q || last_frame_q);
  assign wdt_next  = wdt_q + WW'(1);

  kbd_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_kbd_fifo (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .push_i  (push),
    .dat_i   (KEY_CODE),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Frame timebase: free-runs while enabled, holds otherwise.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)    div_q <= '0;
    else if (ENABLE) div_q <= tick ? '0 : div_q + DW'(1);
  end

  // Frame pending flag; a tick landing on a still-pending frame is counted as overrun.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_pend_q <= 1'b0;
      ovr_q        <= '0;
    end else if (tick) begin
      frame_pend_q <= 1'b1;
      if (frame_pend_q && !frame_clr && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
    end else if (frame_clr) begin
      frame_pend_q <= 1'b0;
    end
  end

  // Sticky error flags for dropped scancodes and out-of-phase handshake strobes.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      kbd_ovf_q <= 1'b0;
      proto_q   <= 1'b0;
    end else begin
      if (push && fifo_full && !pop) kbd_ovf_q <= 1'b1;
      if ((INT_IACK && state_q != ST_PRESENT) || (INT_IEND && state_q != ST_SERVICE))
        proto_q <= 1'b1;
    end
  end

  // Handshake FSM with registered IRQ/key outputs and the service watchdog.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      irq_q        <= IRQ_NONE;
      key_q        <= '0;
      sel_kbd_q    <= 1'b0;
      last_frame_q <= 1'b0;
      wdt_q        <= '0;
      wdt_to_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_pend_q || !fifo_empty) begin
            state_q      <= ST_PRESENT;
            sel_kbd_q    <= pick_kbd;
            last_frame_q <= !pick_kbd;
            irq_q        <= pick_kbd ? IRQ_KBD : IRQ_FRAME;
            if (pick_kbd) key_q <= fifo_head;
          end
        end
        ST_PRESENT: begin
          if (INT_IACK) begin
            state_q <= ST_SERVICE;
            irq_q   <= IRQ_NONE;
            wdt_q   <= '0;
          end
        end
        ST_SERVICE: begin
          if (INT_IEND) begin
            state_q <= ST_IDLE;
          end else if (wdt_q != WDT_LIMIT) begin
            wdt_q <= wdt_next;
            if (wdt_next == WDT_LIMIT) wdt_to_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          irq_q   <= IRQ_NONE;
        end
      endcase
    end
  end

  assign INT_IRQ       = irq_q;
  assign KBD_KEY       = key_q;
  assign FRAME_OVR_CNT = ovr_q;
  assign KBD_OVERFLOW  = kbd_ovf_q;
  assign PROTO_ERROR   = proto_q;
  assign WDT_TIMEOUT   = wdt_to_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench: expected interrupts are queued as stimulus is issued,
// a monitor pops and compares on each new interrupt presentation.
module tb_interrupt_controller;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       ENABLE = 1'b0;
  logic       KEY_VALID = 1'b0;
  logic [7:0] KEY_CODE = 8'h00;
  logic [1:0] INT_IRQ;
  logic       INT_IACK = 1'b0;
  logic       INT_IEND = 1'b0;
  logic [7:0] KBD_KEY;
  logic [7:0] FRAME_OVR_CNT;
  logic       KBD_OVERFLOW;
  logic       PROTO_ERROR;
  logic       WDT_TIMEOUT;

  interrupt_controller #(.TICK_DIV(8), .FIFO_DEPTH(4), .WDT_CYCLES(16)) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .ENABLE        (ENABLE),
    .KEY_VALID     (KEY_VALID),
    .KEY_CODE      (KEY_CODE),
    .INT_IRQ       (INT_IRQ),
    .INT_IACK      (INT_IACK),
    .INT_IEND      (INT_IEND),
    .KBD_KEY       (KBD_KEY),
    .FRAME_OVR_CNT (FRAME_OVR_CNT),
    .KBD_OVERFLOW  (KBD_OVERFLOW),
    .PROTO_ERROR   (PROTO_ERROR),
    .WDT_TIMEOUT   (WDT_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] irq;
    logic [7:0] key;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_frame();
    exp_t e;
    e.irq = 2'd0;
    e.key = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic exp_kbd(input logic [7:0] code);
    exp_t e;
    e.irq = 2'd1;
    e.key = code;
    exp_q.push_back(e);
  endtask

  // Monitor: a new presentation is INT_IRQ leaving 3.
  logic [1:0] prev_irq = 2'd3;
  always @(negedge CLK) begin
    exp_t e;
    if (!RESET_N) begin
      prev_irq = 2'd3;
    end else begin
      if (INT_IRQ != 2'd3 && prev_irq == 2'd3) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_irq: got irq %0d, nothing expected", INT_IRQ);
        end else begin
          e = exp_q.pop_front();
          if (INT_IRQ !== e.irq || (e.irq == 2'd1 && KBD_KEY !== e.key)) begin
            fails++;
            $display("FAIL irq_order: got irq %0d key %0h expected irq %0d key %0h",
                     INT_IRQ, KBD_KEY, e.irq, e.key);
          end
        end
      end
      prev_irq = INT_IRQ;
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    ENABLE = 0; KEY_VALID = 0; INT_IACK = 0; INT_IEND = 0;
    RESET_N = 0;
    @(negedge CLK);
    RESET_N = 1;
  endtask

  task automatic push_key(input logic [7:0] code);
    ENABLE = 1; KEY_VALID = 1; KEY_CODE = code;
    @(negedge CLK);
    ENABLE = 0; KEY_VALID = 0;
  endtask

  task automatic wait_irq(input int budget);
    int n = 0;
    while (INT_IRQ == 2'd3 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (INT_IRQ == 2'd3) begin
      tests++;
      fails++;
      $display("FAIL wait_irq: no interrupt within %0d cycles", budget);
    end
  endtask

  task automatic ack();
    INT_IACK = 1;
    @(negedge CLK);
    INT_IACK = 0;
    chk("irq_none_after_iack", 32'(INT_IRQ), 32'd3);
  endtask

  task automatic iend();
    INT_IEND = 1;
    @(negedge CLK);
    INT_IEND = 0;
  endtask

  task automatic serve();
    wait_irq(40);
    ack();
    iend();
  endtask

  // Enable until a frame is presented, then freeze the divider (it sits at 1 afterwards).
  task automatic get_frame();
    exp_frame();
    ENABLE = 1;
    wait_irq(20);
    ENABLE = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge CLK);
    chk("rst_irq", 32'(INT_IRQ), 32'd3);
    chk("rst_key", 32'(KBD_KEY), 32'd0);
    chk("rst_ovr", 32'(FRAME_OVR_CNT), 32'd0);
    chk("rst_kovf", 32'(KBD_OVERFLOW), 32'd0);
    chk("rst_proto", 32'(PROTO_ERROR), 32'd0);
    chk("rst_wdt", 32'(WDT_TIMEOUT), 32'd0);
    RESET_N = 1;

    // Frame: divider wraps on the 8th enabled edge, IRQ visible after the 9th
    @(negedge CLK);
    exp_frame();
    ENABLE = 1;
    repeat (8) @(negedge CLK);
    chk("frame_not_yet", 32'(INT_IRQ), 32'd3);
    @(negedge CLK);
    chk("frame_timing", 32'(INT_IRQ), 32'd0);
    ENABLE = 0;
    ack();
    iend();
    repeat (3) @(negedge CLK);
    chk("idle_no_irq", 32'(INT_IRQ), 32'd3);
    get_frame();
    ack();
    iend();

    // Single keyboard interrupt
    do_reset();
    exp_kbd(8'h20);
    push_key(8'h20);
    wait_irq(10);
    chk("kbd_key_20", 32'(KBD_KEY), 32'h20);
    ack();
    iend();
    repeat (4) @(negedge CLK);
    chk("fifo_empty_after_iend", 32'(INT_IRQ), 32'd3);

    // Overflow: five pushes during SERVICE, first four delivered in order
    do_reset();
    exp_kbd(8'h11);
    push_key(8'h11);
    wait_irq(10);
    ack();
    for (int i = 1; i <= 4; i++) begin
      exp_kbd(8'hA0 + 8'(i));
      push_key(8'hA0 + 8'(i));
    end
    chk("no_ovf_at_4", 32'(KBD_OVERFLOW), 32'd0);
    push_key(8'hA5);
    chk("ovf_at_5", 32'(KBD_OVERFLOW), 32'd1);
    iend();
    repeat (4) serve();
    chk("kbd_key_held", 32'(KBD_KEY), 32'hA4);

    // Alternation: frame served last, key and tick both pending -> key first
    do_reset();
    get_frame();
    ack();
    exp_kbd(8'h33);
    push_key(8'h33);
    exp_frame();
    ENABLE = 1;
    repeat (10) @(negedge CLK);
    ENABLE = 0;
    iend();
    serve();
    serve();
    chk("alt_no_overrun", 32'(FRAME_OVR_CNT), 32'd0);

    // Overrun: three ticks during SERVICE -> two lost, one frame afterwards
    do_reset();
    get_frame();
    ack();
    ENABLE = 1;
    repeat (24) @(negedge CLK);
    ENABLE = 0;
    chk("ovr_cnt_2", 32'(FRAME_OVR_CNT), 32'd2);
    exp_frame();
    iend();
    serve();
    repeat (6) @(negedge CLK);
    chk("single_frame_after_ovr", 32'(INT_IRQ), 32'd3);

    // Protocol error: IEND in IDLE
    do_reset();
    chk("proto_clear", 32'(PROTO_ERROR), 32'd0);
    iend();
    chk("proto_iend_idle", 32'(PROTO_ERROR), 32'd1);
    chk("proto_no_state_change", 32'(INT_IRQ), 32'd3);

    // Watchdog, then reset in SERVICE
    do_reset();
    exp_kbd(8'h44);
    push_key(8'h44);
    wait_irq(10);
    ack();
    repeat (14) @(negedge CLK);
    chk("wdt_not_yet", 32'(WDT_TIMEOUT), 32'd0);
    repeat (3) @(negedge CLK);
    chk("wdt_timeout", 32'(WDT_TIMEOUT), 32'd1);
    chk("wdt_stays_service", 32'(INT_IRQ), 32'd3);
    push_key(8'h55);
    INT_IACK = 1;
    @(negedge CLK);
    INT_IACK = 0;
    chk("proto_iack_service", 32'(PROTO_ERROR), 32'd1);
    RESET_N = 0;
    #1;
    chk("mid_rst_irq", 32'(INT_IRQ), 32'd3);
    chk("mid_rst_key", 32'(KBD_KEY), 32'd0);
    chk("mid_rst_wdt", 32'(WDT_TIMEOUT), 32'd0);
    chk("mid_rst_proto", 32'(PROTO_ERROR), 32'd0);
    @(negedge CLK);
    RESET_N = 1;
    repeat (10) @(negedge CLK);
    chk("pending_discarded", 32'(INT_IRQ), 32'd3);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
